// File: rtl/pwm_sched.sv
// pwm_sched: round-robin scheduler sharing one execution unit across NUM_CH PWM compare registers.
// Latency: req_i to ex_start_o 2 cycles minimum, ex_done_i to cmp_valid_o 1 cycle; one job in flight,
// extra requests merge into pending and raise overrun. Optional watchdog: define PPWM_SCHED_TIMEOUT_EN.
module pwm_sched #(
  parameter int NUM_CH         = 4,
  parameter int COUNTER_WIDTH  = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH-1:0]                 req_i,
  output logic                              ex_start_o,
  output logic [$clog2(NUM_CH)-1:0]         ex_ch_o,
  input  logic                              ex_done_i,
  input  logic [COUNTER_WIDTH-1:0]          ex_value_i,
  output logic [NUM_CH*COUNTER_WIDTH-1:0]   cmp_value_o,
  output logic [NUM_CH-1:0]                 cmp_valid_o,
  output logic                              busy_o,
  output logic [NUM_CH-1:0]                 overrun_o,
  output logic                              err_timeout_o
);

  localparam int CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("pwm_sched: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                                 state_q, state_d;
  logic [NUM_CH-1:0]                      pending_q;
  logic [NUM_CH-1:0]                      overrun_q;
  logic [NUM_CH-1:0]                      valid_q;
  logic [NUM_CH-1:0][COUNTER_WIDTH-1:0]   cmp_q;
  logic [CH_W-1:0]                        last_q;
  logic [CH_W-1:0]                        grant_q;

  logic [CH_W-1:0]   pick;
  logic              found;
  logic              wd_expire;
  logic              done_ok;
  logic              job_end;
  logic [NUM_CH-1:0] clr_mask;

  // Round-robin: first pending channel above the last one served, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!found && pending_q[CH_W'((int'(last_q) + i) % NUM_CH)]) begin
        found = 1'b1;
        pick  = CH_W'((int'(last_q) + i) % NUM_CH);
      end
    end
  end

  // Completion wins over a watchdog expiry in the same cycle.
  assign done_ok = (state_q == WAIT) && ex_done_i;
  assign job_end = done_ok || ((state_q == WAIT) && wd_expire);

  always_comb begin
    clr_mask = '0;
    if (job_end) clr_mask[grant_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ex_start_o = 1'b0;
    busy_o     = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (found) state_d = ISSUE;
      end
      ISSUE: begin
        ex_start_o = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (ex_done_i || wd_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      overrun_q <= '0;
      valid_q   <= '0;
      cmp_q     <= '0;
      last_q    <= CH_W'(NUM_CH - 1);
      grant_q   <= '0;
    end else begin
      valid_q <= '0;
      if (state_q == IDLE && found) grant_q <= pick;
      if (job_end) last_q <= grant_q;
      if (done_ok) begin
        cmp_q[grant_q]   <= ex_value_i;
        valid_q[grant_q] <= 1'b1;
      end
      // A request coinciding with its own clear re-arms without counting as overrun.
      overrun_q <= overrun_q | (req_i & pending_q & ~clr_mask);
      pending_q <= (pending_q & ~clr_mask) | req_i;
    end
  end

`ifdef PPWM_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wd_expire = (state_q == WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == WAIT) wd_cnt <= wd_cnt + 1'b1;
      else                 wd_cnt <= '0;
      if (wd_expire && !ex_done_i) err_q <= 1'b1;
    end
  end

  assign err_timeout_o = err_q;
`else
  assign wd_expire     = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  assign ex_ch_o     = grant_q;
  assign cmp_value_o = cmp_q;
  assign cmp_valid_o = valid_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pwm_sched.sv
// Self-checking bench for pwm_sched: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the scheduling rules.
module tb_pwm_sched;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int TO = 8;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_i;
  logic           ex_start_o;
  logic [CW-1:0]  ex_ch_o;
  logic           ex_done_i;
  logic [W-1:0]   ex_value_i;
  logic [N*W-1:0] cmp_value_o;
  logic [N-1:0]   cmp_valid_o;
  logic           busy_o;
  logic [N-1:0]   overrun_o;
  logic           err_timeout_o;

  pwm_sched #(.NUM_CH(N), .COUNTER_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i),
    .ex_start_o(ex_start_o), .ex_ch_o(ex_ch_o),
    .ex_done_i(ex_done_i), .ex_value_i(ex_value_i),
    .cmp_value_o(cmp_value_o), .cmp_valid_o(cmp_valid_o),
    .busy_o(busy_o), .overrun_o(overrun_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state: what the scheduler should hold during the current cycle.
  bit [N-1:0]  m_pend, m_ovr, m_vld;
  logic [W-1:0] m_cmp [N];
  int          m_last, m_grant, m_wcnt, m_pick_nxt;
  bit          m_err, m_active, m_issue, m_start_nxt;

  function automatic int rr_pick(input bit [N-1:0] p, input int last);
    for (int i = 1; i <= N; i++)
      if (p[(last + i) % N]) return (last + i) % N;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pend = '0; m_ovr = '0; m_vld = '0;
    m_last = N - 1; m_grant = 0; m_wcnt = 0; m_pick_nxt = 0;
    m_err = 0; m_active = 0; m_issue = 0; m_start_nxt = 0;
    for (int k = 0; k < N; k++) m_cmp[k] = '0;
  endtask

  // Garbage on req/done while rst is high must be ignored.
  task automatic do_reset();
    rst = 1'b1; req_i = '1; ex_done_i = 1'b1; ex_value_i = '1;
    tick();
    rst = 1'b0; req_i = '0; ex_done_i = 1'b0; ex_value_i = '0;
    model_reset();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"}, 64'(ex_start_o), 64'd0);
    check({tag, "_ch"},    64'(ex_ch_o),    64'd0);
    check({tag, "_busy"},  64'(busy_o),     64'd0);
    check({tag, "_cmp"},   64'(cmp_value_o), 64'd0);
    check({tag, "_vld"},   64'(cmp_valid_o), 64'd0);
    check({tag, "_ovr"},   64'(overrun_o),  64'd0);
    check({tag, "_err"},   64'(err_timeout_o), 64'd0);
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic run_cycle(input logic [N-1:0] r, input bit d, input logic [W-1:0] v);
    logic [N*W-1:0] exp_cmp;
    bit [N-1:0]     clr;
    bit             end_job;
    req_i = r; ex_done_i = d; ex_value_i = v;
    for (int k = 0; k < N; k++) exp_cmp[k*W +: W] = m_cmp[k];
    check("start", 64'(ex_start_o), 64'(m_start_nxt));
    if (m_start_nxt) begin
      m_active = 1; m_issue = 1; m_grant = m_pick_nxt; m_wcnt = 0;
    end
    if (m_active) check("ch", 64'(ex_ch_o), 64'(m_grant));
    check("busy",  64'(busy_o),        64'(m_active));
    check("valid", 64'(cmp_valid_o),   64'(m_vld));
    check("cmp",   64'(cmp_value_o),   64'(exp_cmp));
    check("ovr",   64'(overrun_o),     64'(m_ovr));
    check("err",   64'(err_timeout_o), 64'(m_err));

    m_start_nxt = !m_active && (m_pend != '0);
    if (m_start_nxt) m_pick_nxt = rr_pick(m_pend, m_last);

    clr = '0; m_vld = '0; end_job = 0;
    if (m_active && !m_issue) begin
      if (d) begin
        clr[m_grant] = 1; m_cmp[m_grant] = v; m_vld[m_grant] = 1; end_job = 1;
      end
`ifdef PPWM_SCHED_TIMEOUT_EN
      else if (m_wcnt == TO - 1) begin
        clr[m_grant] = 1; m_err = 1; end_job = 1;
      end
`endif
      else m_wcnt++;
    end
    if (end_job) begin
      m_last = m_grant; m_active = 0;
    end
    m_issue = 0;
    m_ovr  = m_ovr | (r & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | r;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  order[$];
    int  pulses;
    bit  dn, saw;

    // Reset state
    do_reset();
    check_zero("rst");

    // Single request, done three cycles after start
    run_cycle(4'b0001, 0, '0);
    check("r32_t1_start", 64'(ex_start_o), 64'd0);
    run_cycle('0, 0, '0);
    check("r32_t2_start", 64'(ex_start_o), 64'd1);
    check("r32_ch",       64'(ex_ch_o),    64'd0);
    run_cycle('0, 0, '0);
    run_cycle('0, 0, '0);
    run_cycle('0, 0, '0);
    run_cycle('0, 1, 10'h155);
    check("r32_val",  64'(cmp_value_o[W-1:0]), 64'h155);
    check("r32_vld",  64'(cmp_valid_o),        64'b0001);
    check("r32_idle", 64'(busy_o),             64'd0);
    run_cycle('0, 0, '0);
    check("r32_vld_once", 64'(cmp_valid_o), 64'd0);

    // Round-robin over all four channels
    do_reset();
    run_cycle(4'b1111, 0, '0);
    pulses = 0; saw = 0;
    for (int c = 0; c < 20; c++) begin
      dn = saw;
      saw = ex_start_o;
      if (ex_start_o) order.push_back(int'(ex_ch_o));
      if (cmp_valid_o != '0) pulses++;
      run_cycle('0, dn, W'($urandom));
    end
    check("r33_nstart", 64'(order.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("r33_order", 64'(i < order.size() ? order[i] : -1), 64'(i));
    check("r33_pulses", 64'(pulses),    64'd4);
    check("r33_ovr",    64'(overrun_o), 64'd0);

    // Overrun and coincident set/clear on channel 2
    do_reset();
    run_cycle(4'b0100, 0, '0);
    run_cycle(4'b0100, 0, '0);
    run_cycle(4'b0100, 0, '0);
    check("r34_ovr", 64'(overrun_o), 64'b0100);
    run_cycle(4'b0100, 1, 10'h02A);
    check("r34_val",     64'(cmp_value_o[2*W +: W]), 64'h02A);
    check("r34_vld",     64'(cmp_valid_o),           64'b0100);
    check("r34_ovr_keep", 64'(overrun_o),            64'b0100);
    run_cycle('0, 0, '0);
    check("r34_reissue", 64'(ex_start_o), 64'd1);
    check("r34_ch",      64'(ex_ch_o),    64'd2);
    run_cycle('0, 0, '0);
    run_cycle('0, 1, 10'h011);
    check("r34_val2",  64'(cmp_value_o[2*W +: W]), 64'h011);
    check("r34_ovr_end", 64'(overrun_o),           64'b0100);

    // Watchdog: no done after start
    do_reset();
    run_cycle(4'b0001, 0, '0);
    run_cycle('0, 0, '0);
    check("r35_start", 64'(ex_start_o), 64'd1);
    for (int i = 0; i < 8; i++) run_cycle('0, 0, '0);
    check("r35_wait8", 64'(busy_o), 64'd1);
    run_cycle('0, 0, '0);
`ifdef PPWM_SCHED_TIMEOUT_EN
    check("r35_idle", 64'(busy_o),        64'd0);
    check("r35_err",  64'(err_timeout_o), 64'd1);
`else
    check("r35_stay", 64'(busy_o),        64'd1);
    check("r35_err",  64'(err_timeout_o), 64'd0);
`endif
    check("r35_cmp", 64'(cmp_value_o[W-1:0]), 64'd0);
    check("r35_vld", 64'(cmp_valid_o),        64'd0);

    // Reset mid-WAIT, then a stray done
    run_cycle(4'b0010, 0, '0);
    run_cycle('0, 0, '0);
    run_cycle('0, 0, '0);
    check("r36_busy_pre", 64'(busy_o), 64'd1);
    do_reset();
    run_cycle('0, 1, 10'h3FF);
    check_zero("r36");

    // Random traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic [N-1:0] r;
      bit           d;
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      d = m_active ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      run_cycle(r, d, W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
